// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: nop encoding, fetch states, IF/ID payload.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef enum logic {RUN, HALT} fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_NOP = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a nop bubble, load captures, otherwise holds.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (reset || flush) q <= IF_ID_NOP;
    else if (load)      q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect/stall/halt control, IF/ID capture.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_BYTES = 32'd32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_pc;
  logic         redirect;
  logic         advance;
  logic         to_halt;
  if_id_t       if_id_d;
  if_id_t       if_id_q;

  always_comb begin
    pc_plus4    = pc + INSTR_BYTES;
    redirect    = branch_taken | jump;
    // Branch is the older instruction, so it wins over a same-cycle jump.
    redirect_pc = branch_taken ? {branch_target[31:2], 2'b00}
                               : {if_id_q.pc4[31:28], jump_index, 2'b00};
    advance     = !redirect && !stall && (state == RUN) && (pc <  IMEM_BYTES);
    to_halt     = !redirect && !stall && (state == RUN) && (pc >= IMEM_BYTES);
    if_id_d     = '{instr: imem_instruction, pc4: pc_plus4, valid: 1'b1};
  end

  if_id_reg u_if_id (
    .clk   (clk),
    .reset (reset),
    .load  (advance),
    .flush (redirect | to_halt),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
      fetch_count  <= 32'h0;
    end else begin
      if (redirect) begin
        pc    <= redirect_pc;
        state <= RUN;
      end else if (advance) begin
        pc          <= pc_plus4;
        fetch_count <= fetch_count + 32'd1;
      end else if (to_halt) begin
        state <= HALT;
      end
      if (branch_taken && (branch_target[1:0] != 2'b00)) misalign_err <= 1'b1;
    end
  end

  assign imem_pc     = pc;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc4   = if_id_q.pc4;
  assign if_id_valid = if_id_q.valid;
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a behavioural fetch model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] imem_pc, imem_instruction, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, halted, misalign_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [8] = '{32'h2001_0001, 32'h2023_0003, 32'h0022_1820, 32'hAC03_0004,
                           32'h8C04_0004, 32'h1084_FFFB, 32'h0800_0002, 32'h0000_000C};

  // Model state: what the spec says the outputs should be after each edge.
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_halt, m_mis;

  always #5 clk = ~clk;

  assign imem_instruction = (imem_pc < 32) ? rom[imem_pc[4:2]] : 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(32'd32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_index(jump_index),
    .imem_pc(imem_pc), .imem_instruction(imem_instruction),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic rs, st, br, input logic [31:0] tgt,
                            input logic j, input logic [25:0] idx);
    if (rs) begin
      m_pc = 32'h0; m_cnt = 32'h0; m_halt = 0; m_mis = 0; bubble();
    end else if (br || j) begin
      if (br && tgt[1:0] != 2'b00) m_mis = 1;
      m_pc   = br ? (tgt & 32'hFFFF_FFFC) : ((m_pc4 & 32'hF000_0000) | (32'(idx) * 4));
      m_halt = 0;
      bubble();
    end else if (st || m_halt) begin
      // frozen
    end else if (m_pc >= 32) begin
      m_halt = 1;
      bubble();
    end else begin
      m_instr = rom[m_pc / 4]; m_pc4 = m_pc + 4; m_valid = 1;
      m_cnt   = m_cnt + 1;     m_pc  = m_pc + 4;
    end
  endtask

  task automatic check_all();
    chk("imem_pc",      imem_pc,      m_pc);
    chk("if_id_instr",  if_id_instr,  m_instr);
    chk("if_id_pc4",    if_id_pc4,    m_pc4);
    chk("if_id_valid",  32'(if_id_valid),  32'(m_valid));
    chk("halted",       32'(halted),       32'(m_halt));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    chk("fetch_count",  fetch_count,  m_cnt);
  endtask

  task automatic tick(input logic rs, st, br, input logic [31:0] tgt,
                      input logic j, input logic [25:0] idx);
    reset = rs; stall = st; branch_taken = br; branch_target = tgt;
    jump = j; jump_index = idx;
    model_step(rs, st, br, tgt, j, idx);
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    reset = 1; stall = 0; branch_taken = 0; branch_target = 0; jump = 0; jump_index = 0;
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0; m_mis = 0; m_cnt = 0;
    @(negedge clk);

    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    // Straight-line fetch.
    tick(0, 0, 0, 0, 0, 0);
    chk("first_capture", if_id_instr, 32'h2001_0001);
    tick(0, 0, 0, 0, 0, 0);
    // Stall two cycles at PC=8.
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    chk("stall_pc", imem_pc, 32'h8);
    tick(0, 0, 0, 0, 0, 0);
    chk("resume_pc", imem_pc, 32'hC);
    tick(0, 0, 0, 0, 0, 0);
    // Branch to 0x4 from PC=0x10.
    tick(0, 0, 1, 32'h4, 0, 0);
    chk("branch_pc", imem_pc, 32'h4);
    tick(0, 0, 0, 0, 0, 0);
    // Branch beats simultaneous jump; then jump alone.
    tick(0, 0, 1, 32'h8, 1, 26'd5);
    chk("branch_wins", imem_pc, 32'h8);
    tick(0, 0, 0, 0, 1, 26'd5);
    chk("jump_pc", imem_pc, 32'h14);
    // Run off the end of the ROM window into HALT.
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0, 0);
    chk("halt_flag", 32'(halted), 32'h1);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 0, 1, 32'h0, 0, 0);
    chk("halt_exit", 32'(halted), 32'h0);
    tick(0, 0, 0, 0, 0, 0);
    // Misaligned redirect, sticky until reset; redirect during stall.
    tick(0, 0, 1, 32'h6, 0, 0);
    chk("misalign_pc", imem_pc, 32'h4);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 1, 26'd3);
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    chk("reset_mis", 32'(misalign_err), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic rs, st, br, j;
      logic [31:0] tgt;
      logic [25:0] idx;
      rs  = ($urandom_range(0, 49) == 0);
      st  = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 11) == 0);
      j   = ($urandom_range(0, 11) == 0);
      tgt = $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0) tgt = tgt | 32'hF000_0000;
      idx = 26'($urandom_range(0, 10));
      tick(rs, st, br, tgt, j, idx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
